fft_butterfly_scheduler: RTL and testbench
==========================================

# fft_butterfly_scheduler

Sequencing controller for an in-place radix-2 decimation-in-time FFT built around a single `ButterflyUnit` and a `twiddleFactorCalculator`. After a `start` pulse it walks all stages and butterflies. For each butterfly it issues one operand-pair read, the twiddle index for that pair, and a delayed write-back of the results to the same two addresses. It sits between the sample RAM (synchronous read, 1-cycle latency, two read and two write ports) and the butterfly datapath. Input samples are already in RAM in bit-reversed order; loading them is out of scope.

## Interface
Parameters:
- `N_LOG2`, default 3: log2 of FFT size N; legal range ≥ 2.
- `RD_LAT`, default 2: cycles from a read issue to the matching write-back (RAM read plus butterfly register); legal range ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `busy`  out  1  high while a transform is in progress.
- `done`  out  1  one-cycle pulse after the final write-back.
- `stage`  out  N_LOG2  index of the stage currently being read (0..N_LOG2-1).
- `rd_en`  out  1  operand-pair read strobe.
- `rd_addr_a`, `rd_addr_b`  out  N_LOG2  upper and lower operand addresses.
- `twiddle_idx`  out  N_LOG2-1  drives `which_factor`; aligned with the RAM read data.
- `wr_en`  out  1  result write strobe.
- `wr_addr_a`, `wr_addr_b`  out  N_LOG2  write-back addresses for `output1` and `output2`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after N/2 reads.
  - DRAIN → RUN (next stage) after RD_LAT cycles, or DRAIN → DONE if the last stage has finished.
  - DONE → IDLE after one cycle.
- Counters:
  - stage counter `s` runs 0..N_LOG2-1.
  - butterfly counter `k` runs 0..N/2-1 and wraps to 0 on each stage change.
- Address generation for stage `s` and butterfly `k`:
  - half = 2^s, pos = k mod half, group = k >> s.
  - `rd_addr_a` = group·2·half + pos.
  - `rd_addr_b` = `rd_addr_a` + half.
  - twiddle exponent = pos << (N_LOG2-1-s).
  - All arithmetic is unsigned in N_LOG2 bits and can never overflow.
- `rd_en`, `rd_addr_*` and `stage` are registered and valid in RUN only. Outside RUN the address outputs hold 0.
- `twiddle_idx` is the twiddle exponent delayed one cycle, so it is aligned with the RAM read data. It is 0 whenever the previous cycle was not a RUN cycle.
- `wr_en` and `wr_addr_*` are `rd_en` and `rd_addr_*` delayed exactly RD_LAT cycles through a shift register.
- DRAIN exists to guarantee that every write of stage s completes before the first read of stage s+1. No read-after-write hazard is allowed.
- `start` while `busy` is ignored. `start` held high in IDLE starts exactly one transform per IDLE visit.
- `reset` mid-transform:
  - next cycle the block is in IDLE with every output 0;
  - in-flight writes are discarded and `wr_en` stays 0 afterwards;
  - no `done` pulse is produced.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Let `start` be sampled high in IDLE at cycle c.
  - The first `rd_en` is at c+1; `busy` rises at c+1.
  - Each stage occupies N/2 consecutive RUN cycles plus RD_LAT DRAIN cycles.
  - `rd_en` is continuous within a stage and low throughout DRAIN.
  - The first `wr_en` is at c+1+RD_LAT.
  - The final `wr_en` falls on the last DRAIN cycle of the last stage, at c+N_LOG2·(N/2+RD_LAT).
  - `done` is high at c+1+N_LOG2·(N/2+RD_LAT). `busy` is low in that same cycle.
- Earliest accepted restart: `start` sampled in the cycle after `done`.
- Throughput: one butterfly per cycle inside RUN. Total 1+N_LOG2·(N/2+RD_LAT) cycles from `start` to `done`.

## Test plan
All scenarios use N_LOG2=3 and RD_LAT=2.
- **Reset/idle:** hold `reset` 3 cycles, then idle 5 cycles → every output stays 0 and there is no `rd_en` or `wr_en` activity.
- **Full sequence:** pulse `start` at cycle c. The (a,b,twiddle) sequence must be:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - Reads at c+1..c+4, c+7..c+10 and c+13..c+16; `done` at c+19.
- **Write alignment:** each `wr_addr` pair equals the `rd_addr` pair from 2 cycles earlier. The last write of stage 0 is at c+6, strictly before the stage-1 read at c+7.
- **Start while busy:** pulse `start` at c+5 and again at c+12 → the schedule is identical to the full-sequence scenario and `done` still pulses once at c+19.
- **Reset mid-operation:** assert `reset` at c+9 → all outputs are 0 from c+10 and no further `wr_en` occurs. A new `start` afterwards produces the full-sequence schedule from the beginning.
- **Back-to-back:** hold `start` high continuously → transforms repeat with `done` at c+19 and the next first read at c+21; `stage` returns to 0 each time.

Source files
------------

// File: rtl/fft_butterfly_scheduler.sv
// rtl/fft_butterfly_scheduler.sv - stage/butterfly sequencer for an in-place radix-2 DIT FFT
module fft_butterfly_scheduler #(
    parameter int N_LOG2 = 3,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] twiddle_idx,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    localparam int KW = N_LOG2 - 1;
    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [N_LOG2-1:0] LAST_STAGE = N_LOG2'(N_LOG2 - 1);
    localparam logic [DW-1:0]     LAST_DRAIN = DW'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [N_LOG2-1:0] s_cnt;
    logic [KW-1:0]     k_cnt;
    logic [KW-1:0]     k_next;
    logic [DW-1:0]     d_cnt;
    logic [KW-1:0]     pos_k;

    logic [RD_LAT-1:0] en_pipe;
    logic [N_LOG2-1:0] a_pipe [RD_LAT];
    logic [N_LOG2-1:0] b_pipe [RD_LAT];

    function automatic logic [N_LOG2-1:0] half_of(input logic [N_LOG2-1:0] s);
        return N_LOG2'(1) << s;
    endfunction

    // Upper operand: group * 2 * half + pos, built as a shift-and-merge.
    function automatic logic [N_LOG2-1:0] base_addr(input logic [N_LOG2-1:0] s,
                                                    input logic [KW-1:0]     k);
        logic [N_LOG2-1:0] kk;
        logic [N_LOG2-1:0] mask;
        kk   = {1'b0, k};
        mask = half_of(s) - N_LOG2'(1);
        return ((kk >> s) << (s + N_LOG2'(1))) | (kk & mask);
    endfunction

    assign k_next = k_cnt + KW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            k_cnt     <= '0;
            d_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        s_cnt     <= '0;
                        k_cnt     <= '0;
                        stage     <= '0;
                        rd_en     <= 1'b1;
                        rd_addr_a <= '0;
                        rd_addr_b <= N_LOG2'(1);
                    end
                end
                RUN: begin
                    if (&k_cnt) begin
                        state     <= DRAIN;
                        d_cnt     <= '0;
                        stage     <= '0;
                        rd_en     <= 1'b0;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                    end else begin
                        k_cnt     <= k_next;
                        rd_addr_a <= base_addr(s_cnt, k_next);
                        rd_addr_b <= base_addr(s_cnt, k_next) + half_of(s_cnt);
                    end
                end
                DRAIN: begin
                    // Hold off the next stage until every write of this one has landed.
                    if (d_cnt == LAST_DRAIN) begin
                        if (s_cnt == LAST_STAGE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            s_cnt     <= s_cnt + N_LOG2'(1);
                            k_cnt     <= '0;
                            stage     <= s_cnt + N_LOG2'(1);
                            rd_en     <= 1'b1;
                            rd_addr_a <= '0;
                            rd_addr_b <= half_of(s_cnt + N_LOG2'(1));
                        end
                    end else begin
                        d_cnt <= d_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    s_cnt <= '0;
                    k_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Twiddle exponent = (a mod half) << (N_LOG2-1-stage); fits in KW bits.
    always_comb begin
        pos_k = KW'(rd_addr_a & (half_of(stage) - N_LOG2'(1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            twiddle_idx <= '0;
        end else begin
            twiddle_idx <= rd_en ? (pos_k << (LAST_STAGE - stage)) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                a_pipe[i] <= '0;
                b_pipe[i] <= '0;
            end
        end else begin
            en_pipe[0] <= rd_en;
            a_pipe[0]  <= rd_addr_a;
            b_pipe[0]  <= rd_addr_b;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe[i] <= en_pipe[i-1];
                a_pipe[i]  <= a_pipe[i-1];
                b_pipe[i]  <= b_pipe[i-1];
            end
        end
    end

    assign wr_en     = en_pipe[RD_LAT-1];
    assign wr_addr_a = a_pipe[RD_LAT-1];
    assign wr_addr_b = b_pipe[RD_LAT-1];

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// tb/tb_fft_butterfly_scheduler.sv - self-checking bench for fft_butterfly_scheduler
module tb_fft_butterfly_scheduler;

    localparam int NS  = 3;
    localparam int L   = 2;
    localparam int NH  = (1 << NS) / 2;
    localparam int P   = NH + L;
    localparam int TOT = NS * P + 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [NS-1:0] stage;
    logic          rd_en;
    logic [NS-1:0] rd_addr_a;
    logic [NS-1:0] rd_addr_b;
    logic [NS-2:0] twiddle_idx;
    logic          wr_en;
    logic [NS-1:0] wr_addr_a;
    logic [NS-1:0] wr_addr_b;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [NS-1:0] stage;
        logic          rd;
        logic [NS-1:0] ra;
        logic [NS-1:0] rb;
        logic [NS-2:0] tw;
        logic          wr;
        logic [NS-1:0] wa;
        logic [NS-1:0] wb;
    } outs_t;

    typedef struct {
        logic  st;
        outs_t want;
    } vec_t;

    outs_t dut_o;
    vec_t  tbl [20];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    m_act = 0;
    int    m_t   = 0;

    fft_butterfly_scheduler #(.N_LOG2(NS), .RD_LAT(L)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .twiddle_idx(twiddle_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b)
    );

    assign dut_o = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, twiddle_idx,
                    wr_en, wr_addr_a, wr_addr_b};

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference: read issued at offset u after an accepted start, from plain arithmetic.
    function automatic void rd_at(input int u, output bit v, output int s, output int a,
                                  output int b, output int e);
        int q, k, h, pos, grp;
        v = 0; s = 0; a = 0; b = 0; e = 0;
        if (u >= 1 && u <= NS * P) begin
            q = u - 1;
            s = q / P;
            k = q % P;
            if (k < NH) begin
                h   = 1 << s;
                pos = k % h;
                grp = k / h;
                v   = 1;
                a   = grp * 2 * h + pos;
                b   = a + h;
                e   = pos * (1 << (NS - 1 - s));
            end
        end
        if (!v) s = 0;
    endfunction

    function automatic outs_t model_outs(input bit act, input int t);
        outs_t o;
        bit v;
        int s, a, b, e;
        o = '0;
        if (act) begin
            o.busy = (t >= 1 && t <= NS * P);
            o.done = (t == TOT);
            rd_at(t, v, s, a, b, e);
            o.rd = v; o.stage = NS'(s); o.ra = NS'(a); o.rb = NS'(b);
            rd_at(t - 1, v, s, a, b, e);
            o.tw = v ? (NS-1)'(e) : '0;
            rd_at(t - L, v, s, a, b, e);
            o.wr = v; o.wa = NS'(a); o.wb = NS'(b);
        end
        return o;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic step(input logic r, input logic s);
        reset = r;
        start = s;
        @(posedge clk);
        cyc++;
        if (r) m_act = 0;
        else if (m_act) begin
            m_t++;
            if (m_t > TOT) m_act = 0;
        end else if (s) begin
            m_act = 1;
            m_t   = 1;
        end
        #1;
        check("model", dut_o, model_outs(m_act, m_t));
    endtask

    function automatic vec_t mk(input logic st, input logic bz, input logic dn,
                                input int sg, input logic rd, input int ra, input int rb,
                                input int tw, input logic wr, input int wa, input int wb);
        vec_t v;
        v.st   = st;
        v.want = {bz, dn, NS'(sg), rd, NS'(ra), NS'(rb), (NS-1)'(tw), wr, NS'(wa), NS'(wb)};
        return v;
    endfunction

    task automatic run_table(input string name, input bit extra_starts, input bit hold);
        logic st;
        for (int i = 0; i < 20; i++) begin
            st = tbl[i].st | hold | (extra_starts && (i == 5 || i == 12));
            step(0, st);
            check(name, dut_o, tbl[i].want);
        end
    endtask

    initial begin
        // Row i: inputs during cycle c+i, outputs expected in cycle c+i+1.
        tbl[0]  = mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 1, 2, 3, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 1, 4, 5, 0, 1, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 1, 6, 7, 0, 1, 2, 3);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 5);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 7);
        tbl[6]  = mk(0, 1, 0, 1, 1, 0, 2, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 1, 1, 3, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 1, 4, 6, 2, 1, 0, 2);
        tbl[9]  = mk(0, 1, 0, 1, 1, 5, 7, 0, 1, 1, 3);
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 4, 6);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 7);
        tbl[12] = mk(0, 1, 0, 2, 1, 0, 4, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 2, 1, 1, 5, 0, 0, 0, 0);
        tbl[14] = mk(0, 1, 0, 2, 1, 2, 6, 1, 1, 0, 4);
        tbl[15] = mk(0, 1, 0, 2, 1, 3, 7, 2, 1, 1, 5);
        tbl[16] = mk(0, 1, 0, 0, 0, 0, 0, 3, 1, 2, 6);
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 7);
        tbl[18] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1;
        start = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            check("reset_zero", dut_o, '0);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            check("idle_zero", dut_o, '0);
        end

        run_table("full_seq", 0, 0);
        step(0, 0);
        run_table("start_busy", 1, 0);
        step(0, 0);

        step(0, 1);
        for (int i = 1; i < 9; i++) step(0, 0);
        step(1, 0);
        check("mid_reset_zero", dut_o, '0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0);
            check("after_reset_quiet", dut_o, '0);
        end
        run_table("restart_seq", 0, 0);

        run_table("b2b_first", 0, 1);
        run_table("b2b_second", 0, 1);
        step(0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
